// File: rtl/axi_4_lite_mst_if.sv
// Command, response and AXI4-Lite master channel bundle for axi_4_lite_mst.
// The master modport is the block's view; the slave modport is the view of whoever drives the block.
interface axi_4_lite_mst_if #(
    parameter int C_AXI_ADDR_WIDTH   = 32,
    parameter int C_AXI_DATA_WIDTH   = 32,
    parameter int C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8
);
    // Command / response side
    logic                          CMD_VALID;
    logic                          CMD_READY;
    logic                          CMD_WRITE;
    logic [C_AXI_ADDR_WIDTH-1:0]   CMD_ADDR;
    logic [C_AXI_DATA_WIDTH-1:0]   CMD_WDATA;
    logic [C_AXI_STROBE_WIDTH-1:0] CMD_WSTRB;
    logic                          RSP_VALID;
    logic                          RSP_READY;
    logic                          RSP_WRITE;
    logic [C_AXI_DATA_WIDTH-1:0]   RSP_RDATA;
    logic [1:0]                    RSP_RESP;

    // AXI4-Lite master side
    logic                          M_AXI_AWVALID;
    logic                          M_AXI_AWREADY;
    logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR;
    logic [2:0]                    M_AXI_AWPROT;
    logic                          M_AXI_WVALID;
    logic                          M_AXI_WREADY;
    logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA;
    logic [C_AXI_STROBE_WIDTH-1:0] M_AXI_WSTRB;
    logic                          M_AXI_BVALID;
    logic                          M_AXI_BREADY;
    logic [1:0]                    M_AXI_BRESP;
    logic                          M_AXI_ARVALID;
    logic                          M_AXI_ARREADY;
    logic [C_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR;
    logic [2:0]                    M_AXI_ARPROT;
    logic                          M_AXI_RVALID;
    logic                          M_AXI_RREADY;
    logic [C_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA;
    logic [1:0]                    M_AXI_RRESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
        output CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
        output M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        input  M_AXI_AWREADY,
        output M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        input  M_AXI_WREADY,
        input  M_AXI_BVALID, M_AXI_BRESP,
        output M_AXI_BREADY,
        output M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        input  M_AXI_ARREADY,
        input  M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        output M_AXI_RREADY
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, CMD_WSTRB, RSP_READY,
        input  CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
        input  M_AXI_AWVALID, M_AXI_AWADDR, M_AXI_AWPROT,
        output M_AXI_AWREADY,
        input  M_AXI_WVALID, M_AXI_WDATA, M_AXI_WSTRB,
        output M_AXI_WREADY,
        output M_AXI_BVALID, M_AXI_BRESP,
        input  M_AXI_BREADY,
        input  M_AXI_ARVALID, M_AXI_ARADDR, M_AXI_ARPROT,
        output M_AXI_ARREADY,
        output M_AXI_RVALID, M_AXI_RDATA, M_AXI_RRESP,
        input  M_AXI_RREADY
    );
endinterface

// File: rtl/axi_4_lite_mst.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI write or read
// and returns the captured response. All handshake outputs are registered.
module axi_4_lite_mst #(
    parameter int C_AXI_ADDR_WIDTH   = 32,
    parameter int C_AXI_DATA_WIDTH   = 32,
    parameter int C_AXI_STROBE_WIDTH = C_AXI_DATA_WIDTH / 8
) (
    input  logic             M_AXI_ACLK,
    input  logic             M_AXI_ARESET,
    axi_4_lite_mst_if.master bus,
    output logic [2:0]       state_dbg
);

    // Every channel uses valid/ready: a transfer happens on the rising edge where both are 1;
    // once raised, a VALID and its payload hold until that edge and drop on the next cycle.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR      = 3'd1,
        WR_RESP = 3'd2,
        RD_ADDR = 3'd3,
        RD_DATA = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                        state;
    logic                          cmd_ready;
    logic                          aw_valid;
    logic                          w_valid;
    logic                          b_ready;
    logic                          ar_valid;
    logic                          r_ready;
    logic                          aw_done;
    logic                          w_done;
    logic                          rsp_valid;
    logic                          rsp_write;
    logic [1:0]                    rsp_resp;
    logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata;
    logic [C_AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [C_AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [C_AXI_DATA_WIDTH-1:0]   w_data;
    logic [C_AXI_STROBE_WIDTH-1:0] w_strb;

    logic                          cmd_accept;
    logic                          aw_hs;
    logic                          w_hs;
    logic                          aw_finished;
    logic                          w_finished;
    logic [C_AXI_ADDR_WIDTH-1:0]   cmd_addr_aligned;

    assign cmd_accept       = bus.CMD_VALID && cmd_ready;
    assign aw_hs            = aw_valid && bus.M_AXI_AWREADY;
    assign w_hs             = w_valid && bus.M_AXI_WREADY;
    assign aw_finished      = aw_done || aw_hs;
    assign w_finished       = w_done || w_hs;
    // Word-aligned bus: the two byte-offset bits never reach the slave.
    assign cmd_addr_aligned = bus.CMD_ADDR & ~C_AXI_ADDR_WIDTH'(3);

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            aw_valid  <= 1'b0;
            w_valid   <= 1'b0;
            b_ready   <= 1'b0;
            ar_valid  <= 1'b0;
            r_ready   <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_write <= 1'b0;
            rsp_resp  <= 2'b00;
            rsp_rdata <= '0;
            aw_addr   <= '0;
            ar_addr   <= '0;
            w_data    <= '0;
            w_strb    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_accept) begin
                        cmd_ready <= 1'b0;
                        if (bus.CMD_WRITE) begin
                            aw_addr  <= cmd_addr_aligned;
                            w_data   <= bus.CMD_WDATA;
                            w_strb   <= bus.CMD_WSTRB;
                            aw_valid <= 1'b1;
                            w_valid  <= 1'b1;
                            aw_done  <= 1'b0;
                            w_done   <= 1'b0;
                            state    <= WR;
                        end else begin
                            ar_addr  <= cmd_addr_aligned;
                            ar_valid <= 1'b1;
                            state    <= RD_ADDR;
                        end
                    end
                end

                // AW and W complete independently, in either order or together.
                WR: begin
                    if (aw_hs) begin
                        aw_valid <= 1'b0;
                        aw_done  <= 1'b1;
                    end
                    if (w_hs) begin
                        w_valid <= 1'b0;
                        w_done  <= 1'b1;
                    end
                    if (aw_finished && w_finished) begin
                        b_ready <= 1'b1;
                        state   <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (b_ready && bus.M_AXI_BVALID) begin
                        b_ready   <= 1'b0;
                        rsp_resp  <= bus.M_AXI_BRESP;
                        rsp_rdata <= '0;
                        rsp_write <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end

                RD_ADDR: begin
                    if (ar_valid && bus.M_AXI_ARREADY) begin
                        ar_valid <= 1'b0;
                        r_ready  <= 1'b1;
                        state    <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    if (r_ready && bus.M_AXI_RVALID) begin
                        r_ready   <= 1'b0;
                        rsp_rdata <= bus.M_AXI_RDATA;
                        rsp_resp  <= bus.M_AXI_RRESP;
                        rsp_write <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end

                // Response fields stay frozen until the consumer takes them.
                RSP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.CMD_READY     = cmd_ready;
    assign bus.RSP_VALID     = rsp_valid;
    assign bus.RSP_WRITE     = rsp_write;
    assign bus.RSP_RDATA     = rsp_rdata;
    assign bus.RSP_RESP      = rsp_resp;

    assign bus.M_AXI_AWVALID = aw_valid;
    assign bus.M_AXI_AWADDR  = aw_addr;
    assign bus.M_AXI_AWPROT  = 3'b000;
    assign bus.M_AXI_WVALID  = w_valid;
    assign bus.M_AXI_WDATA   = w_data;
    assign bus.M_AXI_WSTRB   = w_strb;
    assign bus.M_AXI_BREADY  = b_ready;
    assign bus.M_AXI_ARVALID = ar_valid;
    assign bus.M_AXI_ARADDR  = ar_addr;
    assign bus.M_AXI_ARPROT  = 3'b000;
    assign bus.M_AXI_RREADY  = r_ready;

    assign state_dbg         = state;

endmodule

// File: tb/tb_axi_4_lite_mst.sv
// Bench for axi_4_lite_mst: a word-addressed AXI4-Lite slave model with programmable
// ready delays and response codes, a vector table, and hand-written corner sequences.
module tb_axi_4_lite_mst;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int NV = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] state_dbg;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  axi_4_lite_mst_if #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .C_AXI_STROBE_WIDTH(SW)) bus ();

  axi_4_lite_mst #(.C_AXI_ADDR_WIDTH(AW), .C_AXI_DATA_WIDTH(DW), .C_AXI_STROBE_WIDTH(SW)) dut (
    .M_AXI_ACLK  (clk),
    .M_AXI_ARESET(rst),
    .bus         (bus),
    .state_dbg   (state_dbg)
  );

  // slave model configuration (written by the test) and observations (written by the model)
  int          aw_dly = 0;
  int          w_dly = 0;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [1:0]  rresp_cfg = 2'b00;
  int          b_count = 0;
  int          ord_seen = 0;
  int          ord_bad = 0;
  int          stab_bad = 0;
  int          align_bad = 0;

  logic [31:0] mem [0:63];
  logic        aw_done_s, w_done_s, ar_done_s, b_fire, r_fire, aw_seen;
  int          aw_wait, w_wait;
  logic [31:0] s_awaddr, s_wdata, s_araddr, aw_first;
  logic [3:0]  s_wstrb;

  // Slave decides at the falling edge; a ready raised against a held valid fires on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      bus.M_AXI_AWREADY = 1'b0;
      bus.M_AXI_WREADY  = 1'b0;
      bus.M_AXI_BVALID  = 1'b0;
      bus.M_AXI_BRESP   = 2'b00;
      bus.M_AXI_ARREADY = 1'b0;
      bus.M_AXI_RVALID  = 1'b0;
      bus.M_AXI_RDATA   = '0;
      bus.M_AXI_RRESP   = 2'b00;
      aw_done_s = 1'b0; w_done_s = 1'b0; ar_done_s = 1'b0;
      b_fire = 1'b0; r_fire = 1'b0; aw_seen = 1'b0;
      aw_wait = 0; w_wait = 0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
    end else begin
      if (bus.M_AXI_AWREADY) begin
        bus.M_AXI_AWREADY = 1'b0;
        aw_done_s = 1'b1;
      end else if (bus.M_AXI_AWVALID && !aw_done_s) begin
        if (!aw_seen) begin
          aw_seen = 1'b1;
          aw_first = bus.M_AXI_AWADDR;
        end else if (bus.M_AXI_AWADDR !== aw_first) begin
          stab_bad++;
        end
        if (aw_wait >= aw_dly) begin
          bus.M_AXI_AWREADY = 1'b1;
          s_awaddr = bus.M_AXI_AWADDR;
          if (bus.M_AXI_AWADDR[1:0] != 2'b00 || bus.M_AXI_AWPROT != 3'b000) align_bad++;
        end else begin
          aw_wait++;
        end
      end

      if (bus.M_AXI_WREADY) begin
        bus.M_AXI_WREADY = 1'b0;
        w_done_s = 1'b1;
      end else if (bus.M_AXI_WVALID && !w_done_s) begin
        if (w_wait >= w_dly) begin
          bus.M_AXI_WREADY = 1'b1;
          s_wdata = bus.M_AXI_WDATA;
          s_wstrb = bus.M_AXI_WSTRB;
        end else begin
          w_wait++;
        end
      end

      if (w_done_s && !aw_done_s) begin
        ord_seen++;
        if (bus.M_AXI_WVALID || !bus.M_AXI_AWVALID) ord_bad++;
      end

      if (b_fire) begin
        bus.M_AXI_BVALID = 1'b0;
        b_fire = 1'b0; aw_done_s = 1'b0; w_done_s = 1'b0;
        aw_wait = 0; w_wait = 0; aw_seen = 1'b0;
        b_count++;
      end else if (!bus.M_AXI_BVALID && aw_done_s && w_done_s) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) mem[s_awaddr[7:2]][8*i +: 8] = s_wdata[8*i +: 8];
        bus.M_AXI_BVALID = 1'b1;
        bus.M_AXI_BRESP  = bresp_cfg;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_fire = 1'b1;

      if (bus.M_AXI_ARREADY) begin
        bus.M_AXI_ARREADY = 1'b0;
        ar_done_s = 1'b1;
      end else if (bus.M_AXI_ARVALID && !ar_done_s) begin
        bus.M_AXI_ARREADY = 1'b1;
        s_araddr = bus.M_AXI_ARADDR;
        if (bus.M_AXI_ARADDR[1:0] != 2'b00 || bus.M_AXI_ARPROT != 3'b000) align_bad++;
      end

      if (r_fire) begin
        bus.M_AXI_RVALID = 1'b0;
        r_fire = 1'b0; ar_done_s = 1'b0;
      end else if (!bus.M_AXI_RVALID && ar_done_s) begin
        bus.M_AXI_RVALID = 1'b1;
        bus.M_AXI_RDATA  = mem[s_araddr[7:2]];
        bus.M_AXI_RRESP  = rresp_cfg;
      end
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) r_fire = 1'b1;
    end
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          aw_d;
    int          w_d;
    logic [1:0]  resp_cfg;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t        vecs [NV];
  logic [DW-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for CMD_READY, presents one command for a single cycle and returns once RSP_VALID is seen.
  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, output int lat);
    int n;
    n = 0;
    while (!bus.CMD_READY && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_cmd", {63'd0, bus.CMD_READY}, 64'd1);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = addr;
    bus.CMD_WDATA = wdata;
    bus.CMD_WSTRB = strb;
    @(posedge clk);
    @(negedge clk);
    bus.CMD_VALID = 1'b0;
    lat = 1;
    while (!bus.RSP_VALID && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic complete_rsp();
    bus.RSP_READY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.RSP_READY = 1'b0;
    check("rsp_valid_dropped", {63'd0, bus.RSP_VALID}, 64'd0);
    check("cmd_ready_after_rsp", {63'd0, bus.CMD_READY}, 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int b0, o0, ob0;

    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = '0;
    bus.CMD_WDATA = '0;
    bus.CMD_WSTRB = '0;
    bus.RSP_READY = 1'b0;

    //            wr    addr          wdata          strb  awd wd resp   exp_rdata      exp_resp lat
    vecs[0] = '{1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 32'h0000_0000, 2'b00, 3};
    vecs[1] = '{1'b0, 32'h0000_0000, 32'h0,         4'h0, 0, 0, 2'b00, 32'hDEAD_BEEF, 2'b00, 3};
    vecs[2] = '{1'b1, 32'h0000_0014, 32'hFFFF_FFFF, 4'hF, 0, 0, 2'b00, 32'h0000_0000, 2'b00, 3};
    vecs[3] = '{1'b1, 32'h0000_0014, 32'h0056_3400, 4'h6, 0, 0, 2'b00, 32'h0000_0000, 2'b00, 3};
    vecs[4] = '{1'b0, 32'h0000_0014, 32'h0,         4'h0, 0, 0, 2'b00, 32'hFF56_34FF, 2'b00, 3};
    vecs[5] = '{1'b1, 32'h0000_0020, 32'h1234_5678, 4'hF, 0, 2, 2'b00, 32'h0000_0000, 2'b00, 5};
    vecs[6] = '{1'b1, 32'h0000_0023, 32'hFFFF_FFFF, 4'h0, 0, 0, 2'b00, 32'h0000_0000, 2'b00, 3};
    vecs[7] = '{1'b0, 32'h0000_0022, 32'h0,         4'h0, 0, 0, 2'b00, 32'h1234_5678, 2'b00, 3};
    vecs[8] = '{1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b10, 32'h0000_0000, 2'b10, 3};
    vecs[9] = '{1'b0, 32'h0000_0030, 32'h0,         4'h0, 0, 0, 2'b11, 32'hCAFE_F00D, 2'b11, 3};

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_handshakes", {57'd0, bus.CMD_READY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
          bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.RSP_VALID}, 64'd0);
    check("reset_rsp_fields", {29'd0, bus.RSP_WRITE, bus.RSP_RESP, bus.RSP_RDATA}, 64'd0);
    check("reset_axi_payload", {bus.M_AXI_AWADDR, bus.M_AXI_ARADDR}, 64'd0);
    check("reset_state", {61'd0, state_dbg}, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("cmd_ready_after_reset", {63'd0, bus.CMD_READY}, 64'd1);

    for (int i = 0; i < NV; i++) begin
      aw_dly    = vecs[i].aw_d;
      w_dly     = vecs[i].w_d;
      bresp_cfg = vecs[i].resp_cfg;
      rresp_cfg = vecs[i].resp_cfg;
      exp_q.push_back(vecs[i].exp_rdata);
      b0 = b_count;
      issue_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, lat);
      check($sformatf("v%0d_rdata", i), {32'd0, bus.RSP_RDATA}, {32'd0, exp_q.pop_front()});
      check($sformatf("v%0d_resp", i), {62'd0, bus.RSP_RESP}, {62'd0, vecs[i].exp_resp});
      check($sformatf("v%0d_rsp_write", i), {63'd0, bus.RSP_WRITE}, {63'd0, vecs[i].wr});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      complete_rsp();
      check($sformatf("v%0d_b_count", i), 64'(b_count - b0), vecs[i].wr ? 64'd1 : 64'd0);
    end
    bresp_cfg = 2'b00;
    rresp_cfg = 2'b00;

    // W accepted three cycles before AW: WVALID drops, AWVALID holds, one B
    aw_dly = 3;
    w_dly  = 0;
    b0 = b_count; o0 = ord_seen; ob0 = ord_bad;
    issue_cmd(1'b1, 32'h0000_007C, 32'hA5A5_A5A5, 4'hF, lat);
    check("wfirst_latency", 64'(lat), 64'd6);
    check("wfirst_resp", {61'd0, bus.RSP_WRITE, bus.RSP_RESP}, {61'd0, 1'b1, 2'b00});
    complete_rsp();
    check("wfirst_gap_cycles", 64'(ord_seen - o0), 64'd3);
    check("wfirst_valid_order", 64'(ord_bad - ob0), 64'd0);
    check("wfirst_b_count", 64'(b_count - b0), 64'd1);
    aw_dly = 0;
    issue_cmd(1'b1, 32'h0000_0078, 32'h5A5A_5A5A, 4'hF, lat);
    check("same_cycle_latency", 64'(lat), 64'd3);
    complete_rsp();
    issue_cmd(1'b0, 32'h0000_007C, 32'h0, 4'h0, lat);
    check("rb_7c", {32'd0, bus.RSP_RDATA}, {32'd0, 32'hA5A5_A5A5});
    complete_rsp();
    issue_cmd(1'b0, 32'h0000_0078, 32'h0, 4'h0, lat);
    check("rb_78", {32'd0, bus.RSP_RDATA}, {32'd0, 32'h5A5A_5A5A});
    complete_rsp();

    // response back-pressure; a command offered meanwhile must be ignored
    issue_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0, lat);
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = 32'h0000_0014;
    bus.CMD_WDATA = 32'h0;
    bus.CMD_WSTRB = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d", k), {27'd0, bus.RSP_VALID, bus.CMD_READY, state_dbg, bus.RSP_RDATA},
            {27'd0, 1'b1, 1'b0, 3'd5, 32'hFF56_34FF});
    end
    bus.CMD_VALID = 1'b0;
    complete_rsp();
    issue_cmd(1'b0, 32'h0000_0014, 32'h0, 4'h0, lat);
    check("ignored_cmd_no_effect", {32'd0, bus.RSP_RDATA}, {32'd0, 32'hFF56_34FF});
    complete_rsp();

    // reset while AWVALID is high
    aw_dly = 20;
    w_dly  = 20;
    issue_cmd_start: begin
      check("cmd_ready_pre_reset", {63'd0, bus.CMD_READY}, 64'd1);
      bus.CMD_VALID = 1'b1;
      bus.CMD_WRITE = 1'b1;
      bus.CMD_ADDR  = 32'h0000_0044;
      bus.CMD_WDATA = 32'h0000_0099;
      bus.CMD_WSTRB = 4'hF;
      @(posedge clk);
      @(negedge clk);
      bus.CMD_VALID = 1'b0;
    end
    check("awvalid_pre_reset", {63'd0, bus.M_AXI_AWVALID}, 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_handshakes", {57'd0, bus.CMD_READY, bus.M_AXI_AWVALID, bus.M_AXI_WVALID,
          bus.M_AXI_BREADY, bus.M_AXI_ARVALID, bus.M_AXI_RREADY, bus.RSP_VALID}, 64'd0);
    check("midreset_payload", {bus.M_AXI_AWADDR, bus.M_AXI_WDATA}, 64'd0);
    check("midreset_state", {57'd0, bus.M_AXI_WSTRB, state_dbg}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    aw_dly = 0;
    w_dly  = 0;
    @(posedge clk);
    @(negedge clk);
    check("cmd_ready_after_midreset", {63'd0, bus.CMD_READY}, 64'd1);
    issue_cmd(1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, lat);
    check("post_reset_write", {61'd0, bus.RSP_WRITE, bus.RSP_RESP}, {61'd0, 1'b1, 2'b00});
    check("post_reset_latency", 64'(lat), 64'd3);
    complete_rsp();
    issue_cmd(1'b0, 32'h0000_0040, 32'h0, 4'h0, lat);
    check("post_reset_read", {32'd0, bus.RSP_RDATA}, {32'd0, 32'h1122_3344});
    complete_rsp();

    check("addr_align_prot", 64'(align_bad), 64'd0);
    check("awaddr_stable", 64'(stab_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axi_4_lite_mst.md
AXI_4_LITE_MST -- requirements
Module: axi_4_lite_mst

Interface
REQ-001 SHALL have parameters: C_AXI_ADDR_WIDTH, default 32, AXI address width; C_AXI_DATA_WIDTH, default 32, data width; C_AXI_STROBE_WIDTH, default C_AXI_DATA_WIDTH/8, write strobe width.
REQ-002 SHALL have one clock and a synchronous, active-high reset:
- M_AXI_ACLK  in  1  clock; all logic on rising edge.
- M_AXI_ARESET  in  1  synchronous reset, active-high.
REQ-003 SHALL have these command ports:
- CMD_VALID  in  1  command request.
- CMD_READY  out  1  command accepted when CMD_VALID&&CMD_READY.
- CMD_WRITE  in  1  1=write, 0=read.
- CMD_ADDR  in  C_AXI_ADDR_WIDTH  byte address.
- CMD_WDATA  in  C_AXI_DATA_WIDTH  write data.
- CMD_WSTRB  in  C_AXI_STROBE_WIDTH  byte enables.
REQ-004 SHALL have these response ports:
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed when RSP_VALID&&RSP_READY.
- RSP_WRITE  out  1  response belongs to a write.
- RSP_RDATA  out  C_AXI_DATA_WIDTH  read data; 0 for writes.
- RSP_RESP  out  2  captured BRESP/RRESP.
REQ-005 SHALL have the full AXI4-Lite master port set, prefix M_AXI_: AWVALID/AWREADY/AWADDR/AWPROT(3), WVALID/WREADY/WDATA/WSTRB, BVALID/BREADY/BRESP(2), ARVALID/ARREADY/ARADDR/ARPROT(3), RVALID/RREADY/RDATA/RRESP(2). Directions follow the master role.

Function
REQ-006 SHALL implement FSM states IDLE, WR (AW and W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-007 SHALL drive CMD_READY=1 only in IDLE.
REQ-008 SHALL latch address, data and strobe on command accept, then enter WR (CMD_WRITE=1) or RD_ADDR (CMD_WRITE=0).
REQ-009 SHALL assert AWVALID and WVALID together, from the first cycle of WR; both are registered outputs.
REQ-010 SHALL track AW and W independently with done flags.
- Each VALID deasserts the cycle after its own handshake.
- Either handshake order and a same-cycle handshake SHALL be accepted.
- AWADDR/WDATA/WSTRB SHALL stay stable while the matching VALID is high.
REQ-011 SHALL enter WR_RESP when both AW and W are done, asserting BREADY=1 only in WR_RESP.
REQ-012 SHALL, on BVALID&&BREADY, capture BRESP into RSP_RESP, set RSP_RDATA=0, RSP_WRITE=1, and enter RSP.
REQ-013 SHALL assert ARVALID in RD_ADDR until ARREADY, then enter RD_DATA with RREADY=1.
REQ-014 SHALL, on RVALID&&RREADY, capture RDATA and RRESP, set RSP_WRITE=0, and enter RSP.
REQ-015 SHALL hold RSP_VALID=1 with stable outputs in RSP until RSP_READY, then return to IDLE; CMD_READY rises the following cycle.
- Minimum command-accept-to-RSP_VALID latency: 3 cycles for writes, 3 cycles for reads, with zero-wait slaves.
REQ-016 SHALL force AWADDR[1:0] and ARADDR[1:0] to 0, drive AWPROT=ARPROT=3'b000, and pass WSTRB=0 through unchanged.
REQ-017 SHALL forward SLVERR/DECERR unmodified in RSP_RESP and take no other action.
REQ-018 SHALL ignore CMD_VALID outside IDLE; only one transaction may be outstanding.

Reset
REQ-019 SHALL, on M_AXI_ARESET=1 at a clock edge, enter IDLE from any state, including mid-handshake.
- All VALID/READY outputs SHALL be 0 from the next cycle.
- CMD_READY SHALL be 1 after reset deasserts.
- RSP_RDATA=0, RSP_RESP=2'b00, RSP_WRITE=0, all M_AXI address/data/strobe outputs 0.

Verification
REQ-020 Bench SHALL check: write 0x0 data 0xDEADBEEF strb 4'b1111, then read 0x0 -> RSP_RESP=2'b00, RSP_RDATA=0xDEADBEEF.
REQ-021 Bench SHALL check: write 0x14 0xFFFFFFFF, then write 0x14 0x00563400 strb 4'b0110, then read 0x14 -> 0xFF5634FF.
REQ-022 Bench SHALL check: slave gives WREADY 3 cycles before AWREADY, then same-cycle -> WVALID drops after W handshake, AWVALID held, single B accepted; write to 0x7C 0xA5A5A5A5 reads back.
REQ-023 Bench SHALL check: RSP_READY held low 5 cycles after RSP_VALID -> RSP_VALID and RSP_RDATA stable, CMD_READY=0 throughout.
REQ-024 Bench SHALL check: slave returns BRESP=2'b10 -> RSP_RESP=2'b10, RSP_WRITE=1.
REQ-025 Bench SHALL check: M_AXI_ARESET pulsed while AWVALID=1 -> next cycle all VALIDs 0, CMD_READY=1 after release, subsequent write completes OKAY.
